// File: rtl/forward_ns_rr_pkg.sv
// Shared router types and helpers for the north/south forwarding stage.
// Width and hop-adjust helpers are functions so every instance derives its own.
package forward_ns_rr_pkg;

    typedef enum logic {
        ROUTE = 1'b0,
        LOCAL = 1'b1
    } dir_e;

    function automatic int dy_width(int msb, int lsb);
        return msb - lsb + 1;
    endfunction

    // North hops decrement dy, south hops increment it.
    function automatic int dy_add(bit north);
        return north ? -1 : 1;
    endfunction

    function automatic int strip_width(int pw, int dyw);
        return pw - dyw;
    endfunction

    function automatic logic [31:0] dy_update(logic [31:0] dy, int add);
        return dy + 32'(add);
    endfunction

endpackage

// File: rtl/forward_ns_rr_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// Pointer advances past the winner only when the grant is accepted.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic          hit;
    int            gidx;
    int            idx;

    always_comb begin
        gnt  = '0;
        hit  = 1'b0;
        gidx = 0;
        idx  = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!hit && req[idx]) begin
                hit      = 1'b1;
                gidx     = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (hit && accept) begin
            ptr <= (gidx == N - 1) ? '0 : PW'(gidx + 1);
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Small circular-buffer FIFO with first-word-fall-through head.
// Head reads as zero while empty so a cleared buffer shows a clean output.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] din,
    input  logic         ren,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_w, do_r;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign do_w  = wen && !full;
    assign do_r  = ren && !empty;
    assign dout  = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (do_w) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_w) wp <= wp + 1'b1;
            if (do_r) rp <= rp + 1'b1;
            unique case ({do_w, do_r})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/forward_ns_rr.sv
// North/south forwarding stage: round-robin merge of upstream heads,
// dy hop adjust, then forward to routing buffer or eject to local buffer.
module forward_ns_rr
    import forward_ns_rr_pkg::*;
#(
    parameter int NUM_INPUTS   = 3,
    parameter int PACKET_WIDTH = 21,
    parameter int DY_MSB       = 20,
    parameter int DY_LSB       = 12,
    parameter int BUFFER_DEPTH = 4,
    parameter int NORTH        = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INPUTS*PACKET_WIDTH-1:0]   din,
    input  logic [NUM_INPUTS-1:0]                empty_in,
    output logic [NUM_INPUTS-1:0]                ren_out,
    input  logic                                 ren_in_routing,
    input  logic                                 ren_in_local,
    output logic [PACKET_WIDTH-1:0]              dout_routing,
    output logic [PACKET_WIDTH-(DY_MSB-DY_LSB+1)-1:0] dout_local,
    output logic                                 routing_buffer_empty,
    output logic                                 local_buffer_empty,
    output logic                                 routing_buffer_full,
    output logic                                 local_buffer_full
);

    localparam int DYW = dy_width(DY_MSB, DY_LSB);
    localparam int LW  = strip_width(PACKET_WIDTH, DYW);
    localparam int ADD = dy_add(NORTH != 0);

    logic [PACKET_WIDTH-1:0] pkt [NUM_INPUTS];
    dir_e                    dest [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   req, gnt;
    logic [PACKET_WIDTH-1:0] sel, r_data;
    logic [LW-1:0]           l_data;
    logic [DYW-1:0]          dy_new;
    dir_e                    sel_dir;
    logic                    wen_r, wen_l;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pkt[i]  = din[i*PACKET_WIDTH +: PACKET_WIDTH];
            dest[i] = (pkt[i][DY_MSB:DY_LSB] == '0) ? LOCAL : ROUTE;
            req[i]  = !empty_in[i] &&
                      !((dest[i] == LOCAL) ? local_buffer_full
                                           : routing_buffer_full);
        end
    end

    rr_arbiter #(.N(NUM_INPUTS)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (rst),
        .gnt    (gnt)
    );

    assign ren_out = gnt & {NUM_INPUTS{rst}};

    always_comb begin
        sel     = '0;
        sel_dir = ROUTE;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (gnt[i]) begin
                sel     = pkt[i];
                sel_dir = dest[i];
            end
        end
    end

    // dy arithmetic wraps modulo 2^DYW by truncation.
    always_comb begin
        dy_new = DYW'(dy_update(32'(sel[DY_MSB:DY_LSB]), ADD));
        r_data = sel;
        r_data[DY_MSB:DY_LSB] = dy_new;
        l_data = '0;
        for (int j = 0; j < LW; j++) begin
            if (j < DY_LSB) l_data[j] = sel[j];
            else            l_data[j] = sel[j+DYW];
        end
    end

    assign wen_r = (|ren_out) && (sel_dir == ROUTE);
    assign wen_l = (|ren_out) && (sel_dir == LOCAL);

    sync_fifo #(.W(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH)) u_rbuf (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen_r),
        .din   (r_data),
        .ren   (ren_in_routing),
        .dout  (dout_routing),
        .empty (routing_buffer_empty),
        .full  (routing_buffer_full)
    );

    sync_fifo #(.W(LW), .DEPTH(BUFFER_DEPTH)) u_lbuf (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen_l),
        .din   (l_data),
        .ren   (ren_in_local),
        .dout  (dout_local),
        .empty (local_buffer_empty),
        .full  (local_buffer_full)
    );

endmodule

// File: tb/tb_forward_ns_rr.sv
// Directed-vector bench for forward_ns_rr, north and south instances.
// Table vectors carry buffer state across rows; wrap/reset cases are hand-sequenced.
module tb_forward_ns_rr;

    localparam int N  = 3;
    localparam int PW = 21;
    localparam int LW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*PW-1:0] din;
    logic [N-1:0]    empty_in;
    logic            ren_in_routing, ren_in_local;

    logic [N-1:0]  ren_out, ren_out_s;
    logic [PW-1:0] dout_r, dout_r_s;
    logic [LW-1:0] dout_l, dout_l_s;
    logic r_emp, l_emp, r_full, l_full;
    logic r_emp_s, l_emp_s, r_full_s, l_full_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_ns_rr #(.NORTH(1)) dut (
        .clk(clk), .rst(rst), .din(din), .empty_in(empty_in),
        .ren_out(ren_out), .ren_in_routing(ren_in_routing),
        .ren_in_local(ren_in_local), .dout_routing(dout_r),
        .dout_local(dout_l), .routing_buffer_empty(r_emp),
        .local_buffer_empty(l_emp), .routing_buffer_full(r_full),
        .local_buffer_full(l_full)
    );

    forward_ns_rr #(.NORTH(0)) dut_s (
        .clk(clk), .rst(rst), .din(din), .empty_in(empty_in),
        .ren_out(ren_out_s), .ren_in_routing(ren_in_routing),
        .ren_in_local(ren_in_local), .dout_routing(dout_r_s),
        .dout_local(dout_l_s), .routing_buffer_empty(r_emp_s),
        .local_buffer_empty(l_emp_s), .routing_buffer_full(r_full_s),
        .local_buffer_full(l_full_s)
    );

    function automatic logic [20:0] pk(logic [8:0] dy, logic [11:0] lo);
        return {dy, lo};
    endfunction

    typedef struct {
        logic [20:0] d0, d1, d2;
        logic [2:0]  emp;
        logic        rr, rl;
        logic [2:0]  ren;
        logic        r_emp, r_full;
        logic [20:0] dr;
        logic        l_emp;
        logic [11:0] dl;
    } vec_t;

    vec_t tv[16];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [20:0] d0, logic [20:0] d1, logic [20:0] d2,
                         logic [2:0] emp, logic rr, logic rl);
        din            = {d2, d1, d0};
        empty_in       = emp;
        ren_in_routing = rr;
        ren_in_local   = rl;
    endtask

    initial begin
        tv[0]  = '{pk(9'h003,12'hABC), 0, 0, 3'b110, 0, 0, 3'b001, 0, 0, pk(9'h002,12'hABC), 1, 12'h000};
        tv[1]  = '{0, pk(9'h000,12'h5A5), 0, 3'b101, 1, 0, 3'b010, 1, 0, 21'h0, 0, 12'h5A5};
        tv[2]  = '{pk(9'h100,12'h111), 0, 0, 3'b110, 0, 1, 3'b001, 0, 0, pk(9'h0FF,12'h111), 1, 12'h000};
        tv[3]  = '{pk(9'h001,12'h001), pk(9'h005,12'h002), pk(9'h007,12'h003), 3'b000, 1, 0, 3'b010, 0, 0, pk(9'h004,12'h002), 1, 12'h000};
        tv[4]  = '{pk(9'h001,12'h001), pk(9'h005,12'h002), pk(9'h007,12'h003), 3'b000, 1, 0, 3'b100, 0, 0, pk(9'h006,12'h003), 1, 12'h000};
        tv[5]  = '{pk(9'h001,12'h001), pk(9'h005,12'h002), pk(9'h007,12'h003), 3'b000, 1, 0, 3'b001, 0, 0, pk(9'h000,12'h001), 1, 12'h000};
        tv[6]  = '{pk(9'h001,12'h001), pk(9'h005,12'h002), pk(9'h007,12'h003), 3'b000, 1, 0, 3'b010, 0, 0, pk(9'h004,12'h002), 1, 12'h000};
        tv[7]  = '{pk(9'h001,12'h001), pk(9'h005,12'h002), pk(9'h007,12'h003), 3'b000, 1, 0, 3'b100, 0, 0, pk(9'h006,12'h003), 1, 12'h000};
        tv[8]  = '{pk(9'h001,12'h001), pk(9'h005,12'h002), pk(9'h007,12'h003), 3'b000, 1, 0, 3'b001, 0, 0, pk(9'h000,12'h001), 1, 12'h000};
        tv[9]  = '{pk(9'h001,12'h00A), 0, 0, 3'b110, 0, 0, 3'b001, 0, 0, pk(9'h000,12'h001), 1, 12'h000};
        tv[10] = '{pk(9'h002,12'h00B), 0, 0, 3'b110, 0, 0, 3'b001, 0, 0, pk(9'h000,12'h001), 1, 12'h000};
        tv[11] = '{pk(9'h003,12'h00C), 0, 0, 3'b110, 0, 0, 3'b001, 0, 1, pk(9'h000,12'h001), 1, 12'h000};
        tv[12] = '{pk(9'h001,12'h001), pk(9'h000,12'h777), 0, 3'b100, 0, 0, 3'b010, 0, 1, pk(9'h000,12'h001), 0, 12'h777};
        tv[13] = '{pk(9'h001,12'h001), 0, 0, 3'b110, 1, 0, 3'b000, 0, 0, pk(9'h000,12'h00A), 0, 12'h777};
        tv[14] = '{pk(9'h001,12'h001), 0, 0, 3'b110, 0, 0, 3'b001, 0, 1, pk(9'h000,12'h00A), 0, 12'h777};
        tv[15] = '{0, 0, 0, 3'b111, 1, 1, 3'b000, 0, 0, pk(9'h001,12'h00B), 1, 12'h000};

        // Reset held with traffic present: no pops, buffers clear.
        drive(pk(9'h003,12'h111), pk(9'h004,12'h222), pk(9'h005,12'h333), 3'b000, 0, 0);
        #2;
        chk("rst_ren_out", 32'(ren_out), 32'h0);
        chk("rst_r_empty", 32'(r_emp), 32'h1);
        chk("rst_l_empty", 32'(l_emp), 32'h1);
        chk("rst_r_full", 32'(r_full), 32'h0);
        chk("rst_l_full", 32'(l_full), 32'h0);
        chk("rst_dout_r", 32'(dout_r), 32'h0);
        chk("rst_dout_l", 32'(dout_l), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].d0, tv[i].d1, tv[i].d2, tv[i].emp, tv[i].rr, tv[i].rl);
            #3;
            chk($sformatf("v%0d_ren_out", i), 32'(ren_out), 32'(tv[i].ren));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_r_empty", i), 32'(r_emp), 32'(tv[i].r_emp));
            chk($sformatf("v%0d_r_full", i), 32'(r_full), 32'(tv[i].r_full));
            chk($sformatf("v%0d_dout_r", i), 32'(dout_r), 32'(tv[i].dr));
            chk($sformatf("v%0d_l_empty", i), 32'(l_emp), 32'(tv[i].l_emp));
            chk($sformatf("v%0d_dout_l", i), 32'(dout_l), 32'(tv[i].dl));
        end

        // Mid-stream reset discards buffered packets immediately.
        drive(pk(9'h003,12'h111), pk(9'h004,12'h222), pk(9'h005,12'h333), 3'b000, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ren_out", 32'(ren_out), 32'h0);
        chk("mid_rst_r_empty", 32'(r_emp), 32'h1);
        chk("mid_rst_r_full", 32'(r_full), 32'h0);
        chk("mid_rst_l_empty", 32'(l_emp), 32'h1);
        chk("mid_rst_dout_r", 32'(dout_r), 32'h0);
        chk("mid_rst_s_r_empty", 32'(r_emp_s), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;

        // First grant after reset is channel 0; local read while empty ignored.
        drive(pk(9'h1FE,12'h123), pk(9'h005,12'h001), pk(9'h006,12'h002), 3'b000, 0, 1);
        #3;
        chk("post_rst_ren_out", 32'(ren_out), 32'h1);
        @(posedge clk);
        #1;
        chk("north_dy_dec", 32'(dout_r), 32'(pk(9'h1FD,12'h123)));
        chk("south_wrap_1fe", 32'(dout_r_s), 32'(pk(9'h1FF,12'h123)));
        chk("empty_read_l_empty", 32'(l_emp), 32'h1);

        // North 0x100 -> 0x0FF; south 0x100 -> 0x101.
        drive(pk(9'h100,12'h0F0), 0, 0, 3'b110, 1, 0);
        #3;
        chk("wrap_ren_out", 32'(ren_out), 32'h1);
        @(posedge clk);
        #1;
        chk("north_wrap_100", 32'(dout_r), 32'(pk(9'h0FF,12'h0F0)));
        chk("south_100", 32'(dout_r_s), 32'(pk(9'h101,12'h0F0)));
        chk("wrap_r_empty", 32'(r_emp), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
